// File: rtl/xdma_iob_rd_downsize.sv
// rtl/xdma_iob_rd_downsize.sv - reads DW_IOB-wide IOB words and emits them as two DWIDTH GIF beats
//
// Purpose: on start, reads len_words consecutive words from IOB0 or IOB1, starting at base_addr.
//          Each word is sent as two beats: the low half first, then the high half.
//          mlast marks the high half of the final word. A one-cycle done pulse follows.
// Optional feature: define XDMA_RD_PREFETCH_EN to add a spare word buffer. The next IOB read
//          is then issued while the current word's low half is on the bus.
// Ports:
//   xclk, xreset                    clock, synchronous active-high reset
//   start, sel_iob1, base_addr,
//   len_words                       transfer request, sampled in IDLE
//   busy, done                      status
//   iobN_addr/read/cs               IOB read request (only the selected IOB is ever driven)
//   iobN_rdata/dready               IOB read response
//   mdata, mvalid, mlast, sready    GIF beat stream
module xdma_iob_rd_downsize #(
  parameter int DWIDTH = 128,
  parameter int DW_IOB = 256,
  parameter int AW_IOB = 12
) (
  input  logic              xclk,
  input  logic              xreset,
  input  logic              start,
  input  logic              sel_iob1,
  input  logic [AW_IOB-1:0] base_addr,
  input  logic [AW_IOB:0]   len_words,
  output logic              busy,
  output logic              done,
  output logic [AW_IOB-1:0] iob0_addr,
  output logic              iob0_read,
  output logic              iob0_cs,
  input  logic [DW_IOB-1:0] iob0_rdata,
  input  logic              iob0_dready,
  output logic [AW_IOB-1:0] iob1_addr,
  output logic              iob1_read,
  output logic              iob1_cs,
  input  logic [DW_IOB-1:0] iob1_rdata,
  input  logic              iob1_dready,
  output logic [DWIDTH-1:0] mdata,
  output logic              mvalid,
  output logic              mlast,
  input  logic              sready
);

  typedef enum logic [2:0] {IDLE, RD, WAIT, SEND_LO, SEND_HI, DONE} state_t;

  state_t              state_q, state_d;
  logic                sel_q, sel_d;
  logic [AW_IOB-1:0]   addr_q, addr_d;
  logic [AW_IOB:0]     remain_q, remain_d;
  logic [DW_IOB-1:0]   buf_q, buf_d;
`ifdef XDMA_RD_PREFETCH_EN
  logic [DW_IOB-1:0]   spare_q, spare_d;
  logic                spare_full_q, spare_full_d;
  logic                pf_pend_q, pf_pend_d;   // prefetch read issued, data not yet returned
`endif

  logic                rd_cs, rd_read;
  logic [AW_IOB-1:0]   rd_addr;
  logic                dready_sel;
  logic [DW_IOB-1:0]   rdata_sel;

  assign dready_sel = sel_q ? iob1_dready : iob0_dready;
  assign rdata_sel  = sel_q ? iob1_rdata  : iob0_rdata;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    buf_d    = buf_q;
    rd_cs    = 1'b0;
    rd_read  = 1'b0;
    rd_addr  = addr_q;
    mvalid   = 1'b0;
    mdata    = '0;
    mlast    = 1'b0;
    done     = 1'b0;
    busy     = (state_q != IDLE);
`ifdef XDMA_RD_PREFETCH_EN
    spare_d      = spare_q;
    spare_full_d = spare_full_q;
    pf_pend_d    = pf_pend_q;
    // A prefetched word returning while a beat is on the bus parks in the spare buffer.
    // The SEND_HI branch below overrides this when it can consume the word directly.
    if (pf_pend_q && dready_sel && (state_q == SEND_LO || state_q == SEND_HI)) begin
      spare_d      = rdata_sel;
      spare_full_d = 1'b1;
      pf_pend_d    = 1'b0;
    end
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d    = sel_iob1;
          addr_d   = base_addr;
          remain_d = len_words;
          state_d  = (len_words == '0) ? DONE : RD;
        end
      end
      RD: begin
        rd_cs   = 1'b1;
        rd_read = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        rd_cs = 1'b1;
        if (dready_sel) begin
          buf_d   = rdata_sel;
          state_d = SEND_LO;
`ifdef XDMA_RD_PREFETCH_EN
          pf_pend_d = 1'b0;
`endif
        end
      end
      SEND_LO: begin
        mvalid = 1'b1;
        mdata  = buf_q[DWIDTH-1:0];
`ifdef XDMA_RD_PREFETCH_EN
        if (remain_q > (AW_IOB+1)'(1) && !pf_pend_q && !spare_full_q) begin
          rd_cs     = 1'b1;
          rd_read   = 1'b1;
          rd_addr   = addr_q + AW_IOB'(1);
          pf_pend_d = 1'b1;
        end
`endif
        if (sready) state_d = SEND_HI;
      end
      SEND_HI: begin
        mvalid = 1'b1;
        mdata  = buf_q[DW_IOB-1:DWIDTH];
        mlast  = (remain_q == (AW_IOB+1)'(1));
        if (sready) begin
          remain_d = remain_q - (AW_IOB+1)'(1);
          if (remain_q == (AW_IOB+1)'(1)) begin
            state_d = DONE;
          end else begin
            addr_d = addr_q + AW_IOB'(1);
`ifdef XDMA_RD_PREFETCH_EN
            if (spare_full_q) begin
              buf_d        = spare_q;
              spare_full_d = 1'b0;
              state_d      = SEND_LO;
            end else if (pf_pend_q && dready_sel) begin
              // Word arriving this very cycle: bypass the spare to avoid an mvalid gap.
              buf_d        = rdata_sel;
              spare_full_d = 1'b0;
              pf_pend_d    = 1'b0;
              state_d      = SEND_LO;
            end else begin
              state_d = WAIT;
            end
`else
            state_d = RD;
`endif
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign iob0_cs   = rd_cs & ~sel_q;
  assign iob1_cs   = rd_cs & sel_q;
  assign iob0_read = rd_read & ~sel_q;
  assign iob1_read = rd_read & sel_q;
  assign iob0_addr = (rd_cs && !sel_q) ? rd_addr : '0;
  assign iob1_addr = (rd_cs && sel_q) ? rd_addr : '0;

  always_ff @(posedge xclk) begin
    if (xreset) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      addr_q   <= '0;
      remain_q <= '0;
      buf_q    <= '0;
`ifdef XDMA_RD_PREFETCH_EN
      spare_q      <= '0;
      spare_full_q <= 1'b0;
      pf_pend_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      buf_q    <= buf_d;
`ifdef XDMA_RD_PREFETCH_EN
      spare_q      <= spare_d;
      spare_full_q <= spare_full_d;
      pf_pend_q    <= pf_pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_xdma_iob_rd_downsize.sv
// tb/tb_xdma_iob_rd_downsize.sv - self-checking bench for xdma_iob_rd_downsize
module tb_xdma_iob_rd_downsize;

  logic          xclk = 1'b0;
  logic          xreset = 1'b1;
  logic          start = 1'b0;
  logic          sel_iob1 = 1'b0;
  logic [11:0]   base_addr = '0;
  logic [12:0]   len_words = '0;
  logic          busy, done;
  logic [11:0]   iob0_addr, iob1_addr;
  logic          iob0_read, iob1_read, iob0_cs, iob1_cs;
  logic [255:0]  iob0_rdata = '0, iob1_rdata = '0;
  logic          iob0_dready = 1'b0, iob1_dready = 1'b0;
  logic [127:0]  mdata;
  logic          mvalid, mlast;
  logic          sready = 1'b1;

  xdma_iob_rd_downsize #(.DWIDTH(128), .DW_IOB(256), .AW_IOB(12)) dut (
    .xclk(xclk), .xreset(xreset), .start(start), .sel_iob1(sel_iob1),
    .base_addr(base_addr), .len_words(len_words), .busy(busy), .done(done),
    .iob0_addr(iob0_addr), .iob0_read(iob0_read), .iob0_cs(iob0_cs),
    .iob0_rdata(iob0_rdata), .iob0_dready(iob0_dready),
    .iob1_addr(iob1_addr), .iob1_read(iob1_read), .iob1_cs(iob1_cs),
    .iob1_rdata(iob1_rdata), .iob1_dready(iob1_dready),
    .mdata(mdata), .mvalid(mvalid), .mlast(mlast), .sready(sready)
  );

  always #5 xclk = ~xclk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge xclk) cyc++;

  logic [128:0] exp_q[$];
  int           beat_cyc[$];
  logic [11:0]  addr_log[$];
  int beats = 0, done_cnt = 0, done_cyc = -1, last_beat_cyc = -1;
  int reads = 0, cs_cycles = 0, mv_cycles = 0, viol_mdata = 0, viol_unsel = 0;
  logic cur_sel = 1'b0;
  int lat = 1;
  int start_cyc = 0;

  function automatic logic [255:0] mkword(input logic s, input logic [11:0] a);
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = {4'(i), 3'b0, s, 12'h0, a};
    return w;
  endfunction

  // IOB responder: returns one word `lat` cycles after each read strobe
  logic        m_pend = 1'b0;
  int          m_cnt = 0;
  logic        m_sel = 1'b0;
  logic [11:0] m_addr = '0;
  always @(negedge xclk) begin
    iob0_dready = 1'b0;
    iob1_dready = 1'b0;
    if (m_pend) begin
      if (m_cnt <= 1) begin
        if (m_sel) begin iob1_dready = 1'b1; iob1_rdata = mkword(1'b1, m_addr); end
        else       begin iob0_dready = 1'b1; iob0_rdata = mkword(1'b0, m_addr); end
        m_pend = 1'b0;
      end else begin
        m_cnt--;
      end
    end
    if (iob0_read || iob1_read) begin
      m_pend = 1'b1;
      m_cnt  = lat;
      m_sel  = iob1_read;
      m_addr = iob1_read ? iob1_addr : iob0_addr;
    end
  end

  // Monitor and scoreboard consumer
  always @(negedge xclk) begin
    logic [128:0] e;
    if (mvalid) mv_cycles++;
    if (!mvalid && mdata !== '0) viol_mdata++;
    if (iob0_cs || iob1_cs) cs_cycles++;
    if (cur_sel == 1'b0 && (iob1_cs || iob1_read || iob1_addr != '0)) viol_unsel++;
    if (cur_sel == 1'b1 && (iob0_cs || iob0_read || iob0_addr != '0)) viol_unsel++;
    if (iob0_read || iob1_read) begin
      reads++;
      addr_log.push_back(iob1_read ? iob1_addr : iob0_addr);
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (mvalid && sready) begin
      beats++;
      last_beat_cyc = cyc;
      beat_cyc.push_back(cyc);
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL beat_unexpected: got mdata=%h mlast=%b, required no beat", mdata, mlast);
      end else begin
        e = exp_q.pop_front();
        if ({mdata, mlast} !== e)
          $display("FAIL beat_data: got mdata=%h mlast=%b, required mdata=%h mlast=%b",
                   mdata, mlast, e[128:1], e[0]);
        else n_pass++;
      end
    end
  end

  task automatic push_exp(input logic s, input logic [11:0] b, input int n);
    logic [255:0] w;
    for (int i = 0; i < n; i++) begin
      w = mkword(s, b + 12'(i));
      exp_q.push_back({w[127:0], 1'b0});
      exp_q.push_back({w[255:128], (i == n - 1)});
    end
  endtask

  task automatic pulse_start(input logic s, input logic [11:0] b, input logic [12:0] n);
    @(posedge xclk); #1;
    start = 1'b1; sel_iob1 = s; base_addr = b; len_words = n;
    start_cyc = cyc;
    @(posedge xclk); #1;
    start = 1'b0; sel_iob1 = 1'b0; base_addr = '0; len_words = '0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge xclk);
    n_checks++;
    if (done_cnt == d0) $display("FAIL %s_timeout: no done within %0d cycles, required done", name, budget);
    else n_pass++;
    @(posedge xclk); #1;
  endtask

  task automatic run_xfer(input logic s, input logic [11:0] b, input int n, input string name);
    int d0;
    d0 = done_cnt;
    cur_sel = s;
    push_exp(s, b, n);
    pulse_start(s, b, 13'(n));
    wait_done(200, name);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL %s_beats_left: %0d beats missing, required 0", name, exp_q.size());
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 != 1) $display("FAIL %s_done_count: got %0d, required 1", name, done_cnt - d0);
    else n_pass++;
    n_checks++;
    if (done_cyc != last_beat_cyc + 1)
      $display("FAIL %s_done_timing: done at cycle %0d, required %0d", name, done_cyc, last_beat_cyc + 1);
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_reset;
    xreset = 1'b1;
    repeat (3) @(posedge xclk);
    #1 xreset = 1'b0;
    @(negedge xclk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b, required 0", done); else n_pass++;
    n_checks++; if (mvalid !== 1'b0) $display("FAIL reset_mvalid: got %b, required 0", mvalid); else n_pass++;
    n_checks++; if (mdata !== '0) $display("FAIL reset_mdata: got %h, required 0", mdata); else n_pass++;
    n_checks++;
    if ({iob0_cs, iob0_read, iob1_cs, iob1_read} !== 4'b0 || iob0_addr !== '0 || iob1_addr !== '0)
      $display("FAIL reset_iob: got cs0=%b rd0=%b cs1=%b rd1=%b, required all 0", iob0_cs, iob0_read, iob1_cs, iob1_read);
    else n_pass++;
  endtask

  task automatic test_basic;
    lat = 1; sready = 1'b1;
    run_xfer(1'b0, 12'h010, 2, "basic");
  endtask

  task automatic test_zero_len;
    int c0, b0, m0;
    c0 = cs_cycles; b0 = beats; m0 = mv_cycles;
    cur_sel = 1'b0;
    pulse_start(1'b0, 12'h020, 13'd0);
    wait_done(10, "zero_len");
    n_checks++;
    if (done_cyc <= start_cyc || done_cyc > start_cyc + 2)
      $display("FAIL zero_len_done_timing: done at cycle %0d, start at %0d, required 1..2 later", done_cyc, start_cyc);
    else n_pass++;
    n_checks++; if (cs_cycles != c0) $display("FAIL zero_len_cs: got %0d cs cycles, required 0", cs_cycles - c0); else n_pass++;
    n_checks++;
    if (beats != b0 || mv_cycles != m0) $display("FAIL zero_len_mvalid: got %0d mvalid cycles, required 0", mv_cycles - m0);
    else n_pass++;
  endtask

  task automatic test_wrap;
    int v0;
    v0 = viol_unsel;
    addr_log.delete();
    run_xfer(1'b1, 12'hFFF, 2, "wrap");
    n_checks++;
    if (addr_log.size() != 2) $display("FAIL wrap_read_count: got %0d reads, required 2", addr_log.size());
    else n_pass++;
    n_checks++;
    if (addr_log.size() != 2 || addr_log[0] !== 12'hFFF || addr_log[1] !== 12'h000)
      $display("FAIL wrap_addr: got %h,%h, required fff,000",
               addr_log.size() > 0 ? addr_log[0] : 12'hx, addr_log.size() > 1 ? addr_log[1] : 12'hx);
    else n_pass++;
    n_checks++;
    if (viol_unsel != v0) $display("FAIL wrap_unselected: got %0d active cycles on iob0, required 0", viol_unsel - v0);
    else n_pass++;
  endtask

  task automatic test_stall;
    int b0, r0, k;
    logic [127:0] snap_d;
    logic snap_l, stable;
    lat = 1; sready = 1'b1; cur_sel = 1'b0;
    b0 = beats;
    push_exp(1'b0, 12'h040, 2);
    pulse_start(1'b0, 12'h040, 13'd2);
    k = 0;
    while (beats == b0 && k < 50) begin @(posedge xclk); #1; k++; end
    n_checks++;
    if (beats == b0) $display("FAIL stall_first_beat: no beat within 50 cycles, required 1");
    else n_pass++;
    sready = 1'b0;
    snap_d = mdata; snap_l = mlast; r0 = reads; stable = 1'b1;
    repeat (5) begin
      @(negedge xclk);
      if (mdata !== snap_d || mlast !== snap_l || mvalid !== 1'b1) stable = 1'b0;
    end
    n_checks++;
    if (!stable || snap_d !== mkword(1'b0, 12'h040) >> 128)
      $display("FAIL stall_hold: got mdata=%h mlast=%b, required %h held", mdata, mlast, mkword(1'b0, 12'h040) >> 128);
    else n_pass++;
    n_checks++;
    if (reads != r0) $display("FAIL stall_no_read: got %0d reads during stall, required 0", reads - r0);
    else n_pass++;
    @(posedge xclk); #1 sready = 1'b1;
    wait_done(100, "stall");
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL stall_beats_left: %0d missing, required 0", exp_q.size());
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_reset_mid;
    int b0, d0, r0, m0;
    lat = 2; cur_sel = 1'b0;
    b0 = beats; d0 = done_cnt; r0 = reads; m0 = mv_cycles;
    pulse_start(1'b0, 12'h080, 13'd2);
    @(posedge xclk); #1 xreset = 1'b1;
    @(posedge xclk); #1 xreset = 1'b0;
    repeat (8) @(posedge xclk);
    @(negedge xclk);
    n_checks++; if (reads - r0 != 1) $display("FAIL rstmid_read: got %0d reads, required 1", reads - r0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b, required 0", busy); else n_pass++;
    n_checks++;
    if (beats != b0 || mv_cycles != m0) $display("FAIL rstmid_beats: got %0d mvalid cycles, required 0", mv_cycles - m0);
    else n_pass++;
    n_checks++; if (done_cnt != d0) $display("FAIL rstmid_done: got %0d done pulses, required 0", done_cnt - d0); else n_pass++;
    lat = 1;
  endtask

  task automatic test_back_to_back;
    int k, d0;
    lat = 3; sready = 1'b1; cur_sel = 1'b0;
    d0 = done_cnt;
    push_exp(1'b0, 12'h100, 3);
    pulse_start(1'b0, 12'h100, 13'd3);
    repeat (3) @(posedge xclk);
    #1 start = 1'b1; sel_iob1 = 1'b1; base_addr = 12'h200; len_words = 13'd5;
    @(posedge xclk); #1 start = 1'b0; sel_iob1 = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 100) begin @(posedge xclk); #1; k++; end
    start = 1'b1; sel_iob1 = 1'b0; base_addr = 12'h300; len_words = 13'd1;
    @(posedge xclk); #1 start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL b2b_start_in_done: got busy=%b, required 0", busy);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0 || done_cnt - d0 != 1)
      $display("FAIL b2b_first: got %0d beats left, %0d done, required 0 and 1", exp_q.size(), done_cnt - d0);
    else n_pass++;
    exp_q.delete();
    lat = 1;
    run_xfer(1'b0, 12'h300, 1, "b2b_second");
  endtask

  task automatic test_stream4;
    lat = 1; sready = 1'b1;
    beat_cyc.delete();
    run_xfer(1'b0, 12'h050, 4, "stream4");
    n_checks++;
    if (beat_cyc.size() != 8) $display("FAIL stream4_beats: got %0d, required 8", beat_cyc.size());
    else n_pass++;
`ifdef XDMA_RD_PREFETCH_EN
    n_checks++;
    if (beat_cyc.size() != 8 || beat_cyc[7] - beat_cyc[0] != 7)
      $display("FAIL prefetch_gap: beats spanned %0d cycles, required 8",
               beat_cyc.size() == 8 ? beat_cyc[7] - beat_cyc[0] + 1 : -1);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_stream4();
    n_checks++;
    if (viol_mdata != 0) $display("FAIL mdata_idle_zero: got %0d nonzero cycles, required 0", viol_mdata);
    else n_pass++;
    n_checks++;
    if (viol_unsel != 0) $display("FAIL unselected_iob_idle: got %0d active cycles, required 0", viol_unsel);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
